// File: rtl/rgb_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rgb_wb_pkg
// Description : Shared types and constants for the gray-world white-balance
//               stage: FSM state encoding, gain constants (expressed as
//               integer multiples of 1<<GAIN_FRAC) and the gain width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rgb_wb_pkg;

  typedef enum logic [1:0] {
    S_ACC   = 2'd0,  // accumulating frame statistics
    S_DIV_R = 2'd1,  // dividing sum_g by sum_r
    S_DIV_B = 2'd2,  // dividing sum_g by sum_b
    S_READY = 2'd3   // pending gains waiting for the next frame start
  } wb_state_t;

  // Integer value of the gain; the fixed-point code is this << GAIN_FRAC.
  localparam int GAIN_ONE = 1;
  localparam int GAIN_MAX = 4;

  // Gains are Q2.GAIN_FRAC plus one headroom bit so 4.0 is representable.
  function automatic int gain_width(input int gain_frac);
    return gain_frac + 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : wb_seq_divider
// Description : Restoring radix-2 sequential divider. One quotient bit per
//               cycle; a division occupies DVD_W+1 cycles from start to the
//               done pulse. The quotient is clamped to Q_MAX, and a zero
//               divisor also reports Q_MAX. abort cancels synchronously.
// Ports       : clk, reset      - clock, async active-high reset
//               start, abort    - begin a division / cancel the current one
//               dividend,divisor- operands, sampled on start
//               busy, done      - in progress / one-cycle completion pulse
//               quotient        - clamped result, valid from done onwards
// Revision    : 1.0 - initial release
// ============================================================================
module wb_seq_divider #(
  parameter int             DVD_W = 36,
  parameter int             DVS_W = 28,
  parameter int             Q_W   = 11,
  parameter logic [Q_W-1:0] Q_MAX = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] rem;
  logic [DVD_W-1:0] qd;    // dividend bits shift out, quotient bits shift in
  logic [DVS_W-1:0] dvs;
  logic [CNT_W-1:0] cnt;

  logic [DVS_W:0]   rem_shift;
  logic             ge;
  logic [DVS_W-1:0] rem_next;
  logic [DVD_W-1:0] q_next;

  always_comb begin
    rem_shift = {rem, qd[DVD_W-1]};
    ge        = rem_shift >= {1'b0, dvs};
    rem_next  = ge ? DVS_W'(rem_shift - {1'b0, dvs}) : rem_shift[DVS_W-1:0];
    q_next    = {qd[DVD_W-2:0], ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem      <= '0;
      qd       <= '0;
      dvs      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy <= 1'b0;
      end else if (start) begin
        rem  <= '0;
        qd   <= dividend;
        dvs  <= divisor;
        cnt  <= CNT_W'(DVD_W);
        busy <= 1'b1;
      end else if (busy) begin
        rem <= rem_next;
        qd  <= q_next;
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          if (dvs == '0 || q_next > {{(DVD_W-Q_W){1'b0}}, Q_MAX})
            quotient <= Q_MAX;
          else
            quotient <= q_next[Q_W-1:0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rgb_white_balance.sv
`default_nettype none
// ============================================================================
// Module      : rgb_white_balance
// Description : Gray-world auto white balance. Accumulates per-channel sums
//               over a frame, computes R/B gains relative to G during
//               vertical blanking and applies them (rounded, saturated) to
//               the following frame. Fixed 2-cycle stream latency.
// Ports       : clk, reset                 - clock, async active-high reset
//               r/g/b_data_i, data_i_valid,
//               sop_i, eop_i               - input pixel stream
//               wb_en                      - 1 = apply gains, 0 = unity
//               r/g/b_data_o, data_o_valid,
//               sop_o, eop_o               - balanced stream, 2 cycles later
//               gain_r, gain_b             - active gains (Q2.GAIN_FRAC)
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_white_balance
  import rgb_wb_pkg::*;
#(
  parameter  int DATA_WIDTH  = 8,
  parameter  int FRAME_LINES = 720,
  parameter  int SUM_W       = 28,
  parameter  int GAIN_FRAC   = 8,
  localparam int GAIN_W      = gain_width(GAIN_FRAC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] r_data_i,
  input  logic [DATA_WIDTH-1:0] g_data_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  input  logic                  data_i_valid,
  input  logic                  sop_i,
  input  logic                  eop_i,
  input  logic                  wb_en,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [DATA_WIDTH-1:0] g_data_o,
  output logic [DATA_WIDTH-1:0] b_data_o,
  output logic                  data_o_valid,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic [GAIN_W-1:0]     gain_r,
  output logic [GAIN_W-1:0]     gain_b
);

  localparam int LINE_W = $clog2(FRAME_LINES + 1);
  localparam int DVD_W  = SUM_W + GAIN_FRAC;
  localparam int PROD_W = DATA_WIDTH + GAIN_W;
  localparam logic [GAIN_W-1:0] G_ONE      = GAIN_W'(GAIN_ONE) << GAIN_FRAC;
  localparam logic [GAIN_W-1:0] G_MAX      = GAIN_W'(GAIN_MAX) << GAIN_FRAC;
  localparam logic [PROD_W:0]   ROUND_HALF = (PROD_W+1)'(1) << (GAIN_FRAC - 1);
  localparam logic [PROD_W:0]   PIX_MAX    = (PROD_W+1)'((1 << DATA_WIDTH) - 1);

  // Round-half-up back to pixel scale, then saturate.
  function automatic logic [DATA_WIDTH-1:0] round_sat(input logic [PROD_W-1:0] prod);
    logic [PROD_W:0] scaled;
    scaled = ({1'b0, prod} + ROUND_HALF) >> GAIN_FRAC;
    return (scaled > PIX_MAX) ? '1 : scaled[DATA_WIDTH-1:0];
  endfunction

  wb_state_t         state;
  logic [LINE_W-1:0] line_cnt;
  logic [SUM_W-1:0]  sum_r, sum_g, sum_b;
  logic [GAIN_W-1:0] pend_r, pend_b;

  // ---------------------------------------------------------------- framing
  logic last_line, frame_start, frame_end;
  assign last_line   = (line_cnt == LINE_W'(FRAME_LINES - 1));
  assign frame_start = data_i_valid && sop_i && (line_cnt == '0);
  assign frame_end   = data_i_valid && eop_i && last_line;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      line_cnt <= '0;
    else if (data_i_valid && eop_i)
      line_cnt <= last_line ? '0 : line_cnt + LINE_W'(1);
  end

  // The frame-start pixel replaces the running sum instead of adding to it.
  logic [SUM_W-1:0] next_r, next_g, next_b;
  always_comb begin
    next_r = SUM_W'(r_data_i) + (frame_start ? '0 : sum_r);
    next_g = SUM_W'(g_data_i) + (frame_start ? '0 : sum_g);
    next_b = SUM_W'(b_data_i) + (frame_start ? '0 : sum_b);
  end

  // ---------------------------------------------------------------- divider
  // The R division starts on the frame-end pixel itself, using the sums that
  // include it; the B division chains off the R done pulse using the
  // registered (snapshot) sums.
  logic              div_start, div_abort, div_busy, div_done;
  logic [DVD_W-1:0]  div_dividend;
  logic [SUM_W-1:0]  div_divisor;
  logic [GAIN_W-1:0] div_q;

  assign div_start    = (state == S_ACC && frame_end && !div_busy) ||
                        (state == S_DIV_R && div_done);
  assign div_abort    = frame_start && (state == S_DIV_R || state == S_DIV_B);
  assign div_dividend = (state == S_ACC) ? {next_g, {GAIN_FRAC{1'b0}}}
                                         : {sum_g,  {GAIN_FRAC{1'b0}}};
  assign div_divisor  = (state == S_ACC) ? next_r : sum_b;

  wb_seq_divider #(
    .DVD_W (DVD_W),
    .DVS_W (SUM_W),
    .Q_W   (GAIN_W),
    .Q_MAX (G_MAX)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  // A frame start coinciding with the B done pulse still counts as a
  // completed computation, so the fresh quotient is forwarded directly.
  logic              apply, in_div;
  logic [GAIN_W-1:0] new_r, new_b;
  assign apply  = frame_start && (state == S_READY || (state == S_DIV_B && div_done));
  assign in_div = (state == S_DIV_R) || (state == S_DIV_B);
  assign new_r  = pend_r;
  assign new_b  = (state == S_READY) ? pend_b : div_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_ACC;
      sum_r  <= '0;
      sum_g  <= '0;
      sum_b  <= '0;
      pend_r <= G_ONE;
      pend_b <= G_ONE;
      gain_r <= G_ONE;
      gain_b <= G_ONE;
    end else if (frame_start && (state == S_READY || in_div)) begin
      // New frame while waiting or still dividing: restart accumulation.
      sum_r <= next_r;
      sum_g <= next_g;
      sum_b <= next_b;
      state <= S_ACC;
      if (apply) begin
        gain_r <= new_r;
        gain_b <= new_b;
      end
    end else begin
      case (state)
        S_ACC: begin
          if (data_i_valid) begin
            sum_r <= next_r;
            sum_g <= next_g;
            sum_b <= next_b;
            if (frame_end)
              state <= S_DIV_R;
          end
        end
        S_DIV_R: begin
          if (div_done) begin
            pend_r <= div_q;
            state  <= S_DIV_B;
          end
        end
        S_DIV_B: begin
          if (div_done) begin
            pend_b <= div_q;
            state  <= S_READY;
          end
        end
        default: ;  // S_READY: hold pending gains
      endcase
    end
  end

  // ---------------------------------------------------------------- datapath
  logic [GAIN_W-1:0] use_r, use_b;
  assign use_r = !wb_en ? G_ONE : (apply ? new_r : gain_r);
  assign use_b = !wb_en ? G_ONE : (apply ? new_b : gain_b);

  logic [PROD_W-1:0]     p1_r, p1_b;
  logic [DATA_WIDTH-1:0] p1_g;
  logic                  v1, s1, e1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_r         <= '0;
      p1_b         <= '0;
      p1_g         <= '0;
      v1           <= 1'b0;
      s1           <= 1'b0;
      e1           <= 1'b0;
      r_data_o     <= '0;
      g_data_o     <= '0;
      b_data_o     <= '0;
      data_o_valid <= 1'b0;
      sop_o        <= 1'b0;
      eop_o        <= 1'b0;
    end else begin
      p1_r         <= PROD_W'(r_data_i) * PROD_W'(use_r);
      p1_b         <= PROD_W'(b_data_i) * PROD_W'(use_b);
      p1_g         <= g_data_i;
      v1           <= data_i_valid;
      s1           <= sop_i;
      e1           <= eop_i;
      r_data_o     <= round_sat(p1_r);
      g_data_o     <= p1_g;
      b_data_o     <= round_sat(p1_b);
      data_o_valid <= v1;
      sop_o        <= s1;
      eop_o        <= e1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rgb_white_balance.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb_white_balance
// Description : Randomized self-checking bench for rgb_white_balance with a
//               frame-level gray-world reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_white_balance;

  localparam int DW = 8;
  localparam int FL = 4;   // lines per frame
  localparam int LP = 8;   // pixels per line
  localparam int GW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] r_data_i, g_data_i, b_data_i;
  logic          data_i_valid, sop_i, eop_i, wb_en;
  logic [DW-1:0] r_data_o, g_data_o, b_data_o;
  logic          data_o_valid, sop_o, eop_o;
  logic [GW-1:0] gain_r, gain_b;

  always #5 clk = ~clk;

  rgb_white_balance #(
    .DATA_WIDTH  (DW),
    .FRAME_LINES (FL),
    .SUM_W       (28),
    .GAIN_FRAC   (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .r_data_i     (r_data_i),
    .g_data_i     (g_data_i),
    .b_data_i     (b_data_i),
    .data_i_valid (data_i_valid),
    .sop_i        (sop_i),
    .eop_i        (eop_i),
    .wb_en        (wb_en),
    .r_data_o     (r_data_o),
    .g_data_o     (g_data_o),
    .b_data_o     (b_data_o),
    .data_o_valid (data_o_valid),
    .sop_o        (sop_o),
    .eop_o        (eop_o),
    .gain_r       (gain_r),
    .gain_b       (gain_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ model
  typedef struct {
    bit v, s, e;
    int r, g, b;
  } exp_t;

  exp_t    exp_q[$];
  int      act_r, act_b, pend_r, pend_b, mline;
  bit      pend_ok, frame_done;
  longint  fsum_r, fsum_g, fsum_b;

  function automatic int gain_of(input longint sg, input longint sc);
    longint q;
    if (sc == 0) return 1024;
    q = (sg * 256) / sc;
    return (q > 1024) ? 1024 : int'(q);
  endfunction

  function automatic int apply_gain(input int x, input int g);
    int y;
    y = (x * g + 128) / 256;
    return (y > 255) ? 255 : y;
  endfunction

  task automatic model_reset();
    exp_t z;
    z = '{v: 0, s: 0, e: 0, r: 0, g: 0, b: 0};
    act_r = 256; act_b = 256; pend_r = 256; pend_b = 256;
    pend_ok = 0; frame_done = 0; mline = 0;
    fsum_r = 0; fsum_g = 0; fsum_b = 0;
    exp_q.delete();
    exp_q.push_back(z);
    exp_q.push_back(z);
  endtask

  // One clock of stimulus; checks outputs belonging to two cycles earlier.
  task automatic cycle(input bit v, input bit s, input bit e,
                       input int r, input int g, input int b);
    exp_t ex, nx;
    int   gr, gb;
    data_i_valid = v; sop_i = s; eop_i = e;
    r_data_i = DW'(r); g_data_i = DW'(g); b_data_i = DW'(b);
    @(negedge clk);
    ex = exp_q.pop_front();
    check("valid_o", 32'(data_o_valid), 32'(ex.v));
    check("sop_o",   32'(sop_o),        32'(ex.s));
    check("eop_o",   32'(eop_o),        32'(ex.e));
    if (ex.v) begin
      check("r_o", 32'(r_data_o), 32'(ex.r));
      check("g_o", 32'(g_data_o), 32'(ex.g));
      check("b_o", 32'(b_data_o), 32'(ex.b));
    end
    check("gain_r", 32'(gain_r), 32'(act_r));
    check("gain_b", 32'(gain_b), 32'(act_b));

    if (v && s && mline == 0) begin
      if (pend_ok) begin act_r = pend_r; act_b = pend_b; end
      pend_ok = 0; fsum_r = 0; fsum_g = 0; fsum_b = 0;
    end
    if (v) begin fsum_r += r; fsum_g += g; fsum_b += b; end
    if (v && e) begin
      if (mline == FL - 1) begin
        mline = 0;
        pend_r = gain_of(fsum_g, fsum_r);
        pend_b = gain_of(fsum_g, fsum_b);
        frame_done = 1;
      end else begin
        mline++;
      end
    end

    gr = wb_en ? act_r : 256;
    gb = wb_en ? act_b : 256;
    nx.v = v; nx.s = s; nx.e = e;
    nx.r = apply_gain(r, gr); nx.g = g; nx.b = apply_gain(b, gb);
    exp_q.push_back(nx);
    @(posedge clk); #1;
  endtask

  // Vertical blanking; only long blanking lets the gains finish computing.
  task automatic blank(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    pend_ok    = frame_done && (n >= 80);
    frame_done = 0;
  endtask

  // rnd = 0: constant pixel (r0,g0,b0); rnd = 1: random pixels.
  task automatic run_frame(input bit rnd, input int r0, input int g0, input int b0);
    for (int l = 0; l < FL; l++) begin
      for (int p = 0; p < LP; p++) begin
        if ($urandom_range(0, 3) == 0) cycle(0, 0, 0, 0, 0, 0);
        if (rnd)
          cycle(1, p == 0, p == LP - 1, int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        else
          cycle(1, p == 0, p == LP - 1, r0, g0, b0);
      end
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic do_reset();
    data_i_valid = 0; sop_i = 0; eop_i = 0;
    r_data_i = '0; g_data_i = '0; b_data_i = '0;
    reset = 1'b1;
    #1;
    check("rst_valid", 32'(data_o_valid), 32'd0);
    check("rst_sop",   32'(sop_o),        32'd0);
    check("rst_eop",   32'(eop_o),        32'd0);
    check("rst_r",     32'(r_data_o),     32'd0);
    check("rst_g",     32'(g_data_o),     32'd0);
    check("rst_b",     32'(b_data_o),     32'd0);
    check("rst_gain_r", 32'(gain_r),      32'h100);
    check("rst_gain_b", 32'(gain_b),      32'h100);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    wb_en = 1'b1;
    reset = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // gray frames keep unity gains
    run_frame(0, 100, 100, 100); blank(100);
    run_frame(0, 100, 100, 100); blank(100);

    // R=64 G=128 B=32 -> gains 2.0 / 4.0, balanced output 128
    run_frame(0, 64, 128, 32);   blank(100);
    run_frame(0, 64, 128, 32);   blank(100);
    // R saturates
    run_frame(0, 200, 128, 32);  blank(100);

    // zero red -> divide-by-zero clamp
    run_frame(0, 0, 128, 32);    blank(100);
    run_frame(1, 0, 0, 0);       blank(100);

    // short blanking abandons the computation
    run_frame(1, 0, 0, 0);       blank(10);
    run_frame(1, 0, 0, 0);       blank(100);
    run_frame(1, 0, 0, 0);       blank(int'($urandom_range(90, 120)));
    run_frame(1, 0, 0, 0);       blank(100);

    // bypass with non-unity gains latched
    run_frame(0, 64, 128, 32);   blank(100);
    wb_en = 1'b0;
    run_frame(1, 0, 0, 0);       blank(10);
    wb_en = 1'b1;

    // reset in the middle of a line
    for (int p = 0; p < LP; p++) cycle(1, p == 0, p == LP - 1, 50, 60, 70);
    cycle(1, 1, 0, 50, 60, 70);
    cycle(1, 0, 0, 50, 60, 70);
    do_reset();
    run_frame(1, 0, 0, 0);       blank(100);
    run_frame(1, 0, 0, 0);       blank(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
